insn_mem_loader: RTL and testbench

- Responder side of the CPU instruction-fetch port.
- Owns the instruction RAM and boot-loads it from a byte stream (UART/debug bridge), assembling little-endian words.
- Releases the core through cpu_en once loading completes.
- While running, serves each rd_insn_en/pc request with insn one cycle later.

---
 rtl/insn_mem_loader_pkg.sv | 24 ++
 rtl/insn_mem_loader_ram.sv | 31 +++
 rtl/insn_mem_loader.sv | 143 ++++++++++++++
 tb/tb_insn_mem_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/insn_mem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: widths, the NOP
// returned for invalid fetches, and the loader/fetch state encodings.
package insn_mem_loader_pkg;

  localparam int PC_WIDTH   = 32;
  localparam int WORD_WIDTH = 32;
  localparam int DEPTH_LOG2 = 12;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Where the registered insn output is sourced from.
  typedef enum logic {
    SRC_NOP = 1'b0,
    SRC_RAM = 1'b1
  } insn_src_e;

endpackage

// File: rtl/insn_mem_loader_ram.sv
// Simple dual-port synchronous RAM, one write port and one registered read
// port; kept as its own module so a vendor block RAM can replace it.
module insn_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // q only moves on a read, so it holds the last fetched word otherwise.
  always_ff @(posedge clk) begin
    if (re) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/insn_mem_loader.sv
// Boot-loads the instruction RAM from a little-endian byte stream, then
// enables the core and serves its fetches with one cycle of latency.
module insn_mem_loader #(
  parameter int                            PC_WIDTH   = insn_mem_loader_pkg::PC_WIDTH,
  parameter int                            WORD_WIDTH = insn_mem_loader_pkg::WORD_WIDTH,
  parameter int                            DEPTH_LOG2 = insn_mem_loader_pkg::DEPTH_LOG2,
  parameter logic [WORD_WIDTH-1:0]         NOP_INSN   = insn_mem_loader_pkg::NOP_INSN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot_start,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [7:0]            load_byte,
  input  logic                  load_last,
  output logic                  load_done,
  output logic                  load_err,
  output logic [DEPTH_LOG2:0]   word_count,
  output logic                  cpu_en,
  input  logic                  rd_insn_en,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic [WORD_WIDTH-1:0] insn,
  output logic [1:0]            dbg_state_o
);

  import insn_mem_loader_pkg::*;

  // Byte stream handshake: a byte transfers on a rising edge where
  // load_valid & load_ready are both high and boot_start is low; load_ready
  // depends only on state, never on load_valid.

  state_e                  state_q, state_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [WORD_WIDTH-1:0]   buf_q, buf_d;
  logic [DEPTH_LOG2:0]     wc_q, wc_d;
  logic                    err_q, err_d;
  logic                    cpu_en_q;
  insn_src_e               src_q, src_d;

  logic                    accept;
  logic                    wr_en;
  logic                    at_top;
  logic [WORD_WIDTH-1:0]   wr_word;
  logic [DEPTH_LOG2-1:0]   wr_addr;
  logic                    pc_ok;
  logic                    ram_re;
  logic [WORD_WIDTH-1:0]   ram_q;

  assign accept  = (state_q == ST_LOAD) && load_valid && !boot_start;
  assign wr_en   = accept && ((byte_idx_q == 2'd3) || load_last);
  assign wr_addr = wc_q[DEPTH_LOG2-1:0];
  assign at_top  = (wr_addr == {DEPTH_LOG2{1'b1}});

  // Unreceived upper bytes are already zero because buf_q clears on every write.
  always_comb begin
    wr_word = buf_q;
    wr_word[{byte_idx_q, 3'b000} +: 8] = load_byte;
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    buf_d      = buf_q;
    wc_d       = wc_q;
    err_d      = err_q;
    if (boot_start) begin
      state_d    = ST_LOAD;
      byte_idx_d = 2'd0;
      buf_d      = '0;
      wc_d       = '0;
      err_d      = 1'b0;
    end else if (accept) begin
      if (wr_en) begin
        byte_idx_d = 2'd0;
        buf_d      = '0;
        wc_d       = wc_q + (DEPTH_LOG2+1)'(1);
        if (load_last) begin
          state_d = ST_RUN;
        end else if (at_top) begin
          state_d = ST_RUN;
          err_d   = 1'b1;
        end
      end else begin
        byte_idx_d = byte_idx_q + 2'd1;
        buf_d      = wr_word;
      end
    end
  end

  assign pc_ok  = (pc[1:0] == 2'b00) && (pc[PC_WIDTH-1:DEPTH_LOG2+2] == '0);
  assign ram_re = (state_q == ST_RUN) && rd_insn_en && pc_ok;

  always_comb begin
    src_d = src_q;
    if (state_q != ST_RUN) begin
      src_d = SRC_NOP;
    end else if (rd_insn_en) begin
      src_d = pc_ok ? SRC_RAM : SRC_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= 2'd0;
      buf_q      <= '0;
      wc_q       <= '0;
      err_q      <= 1'b0;
      cpu_en_q   <= 1'b0;
      src_q      <= SRC_NOP;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      buf_q      <= buf_d;
      wc_q       <= wc_d;
      err_q      <= err_d;
      cpu_en_q   <= (state_d == ST_RUN);
      src_q      <= src_d;
    end
  end

  insn_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (WORD_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_word),
    .re    (ram_re),
    .raddr (pc[DEPTH_LOG2+1:2]),
    .q     (ram_q)
  );

  assign load_ready  = (state_q == ST_LOAD);
  assign load_done   = (state_q == ST_RUN);
  assign load_err    = err_q;
  assign word_count  = wc_q;
  assign cpu_en      = cpu_en_q;
  assign insn        = ((state_q == ST_RUN) && (src_q == SRC_RAM)) ? ram_q : NOP_INSN;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_insn_mem_loader.sv
// Directed and randomized checks of the instruction-memory loader against a
// byte-stream / word-array reference model.
module tb_insn_mem_loader;

  localparam int          DL    = 12;
  localparam int          DEPTH = 4096;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, boot_start, load_valid, load_last, rd_insn_en;
  logic [7:0]  load_byte;
  logic        load_ready, load_done, load_err, cpu_en;
  logic [DL:0] word_count;
  logic [31:0] pc, insn;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model_mem [DEPTH];
  bit          known     [DEPTH];
  logic [7:0]  load_q [$];
  logic [31:0] exp_q  [$];

  insn_mem_loader dut (
    .clk         (clk),
    .rst         (rst),
    .boot_start  (boot_start),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_byte   (load_byte),
    .load_last   (load_last),
    .load_done   (load_done),
    .load_err    (load_err),
    .word_count  (word_count),
    .cpu_en      (cpu_en),
    .rd_insn_en  (rd_insn_en),
    .pc          (pc),
    .insn        (insn),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_boot();
    boot_start = 1'b1;
    step();
    boot_start = 1'b0;
  endtask

  // Streams load_q with random idle gaps; load_last on the final byte if asked.
  task automatic send_load(input bit with_last);
    for (int i = 0; i < load_q.size(); i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) step();
      load_valid = 1'b1;
      load_byte  = load_q[i];
      load_last  = with_last && (i == load_q.size() - 1);
      step();
      load_valid = 1'b0;
      load_last  = 1'b0;
      load_byte  = 8'($urandom);
    end
  endtask

  // Reference: image words are consecutive little-endian byte groups, zero padded.
  task automatic model_commit();
    int nw;
    nw = (load_q.size() + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] word;
      word = 32'h0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < load_q.size()) word[8*k +: 8] = load_q[4*w + k];
      end
      model_mem[w] = word;
      known[w]     = 1'b1;
    end
  endtask

  task automatic fetch_check(input logic [31:0] a);
    logic [31:0] e;
    if (a[1:0] == 2'b00 && a[31:14] == 18'h0) e = model_mem[a[13:2]];
    else e = NOP;
    exp_q.push_back(e);
    rd_insn_en = 1'b1;
    pc         = a;
    step();
    rd_insn_en = 1'b0;
    pc         = $urandom;
    chk("fetch", insn, exp_q.pop_front());
    step();
    chk("hold", insn, e);
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    int acc;
    int nw;
    rst = 1'b1; boot_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_byte = 8'h0; rd_insn_en = 1'b0; pc = 32'h0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    // Reset
    repeat (2) step();
    rst = 1'b0;
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_insn", insn, NOP);
    chk("rst_word_count", 32'(word_count), 32'd0);

    // First 4-byte image
    pulse_boot();
    chk("load_ready_in_load", 32'(load_ready), 32'd1);
    chk("cpu_en_in_load", 32'(cpu_en), 32'd0);
    load_q = '{8'h93, 8'h00, 8'h50, 8'h00};
    send_load(1'b1);
    chk("w1_load_done", 32'(load_done), 32'd1);
    chk("w1_cpu_en", 32'(cpu_en), 32'd1);
    chk("w1_word_count", 32'(word_count), 32'd1);
    chk("w1_load_ready", 32'(load_ready), 32'd0);
    model_commit();
    fetch_check(32'h0000_0000);
    chk("w1_word_value", insn, 32'h0050_0093);
    fetch_check(32'h0000_0002);
    fetch_check(32'h0000_4000);
    fetch_check(32'h0000_0000);

    // 6-byte image with partial final word; insn forced to NOP while loading
    pulse_boot();
    chk("insn_nop_in_load", insn, NOP);
    chk("cpu_en_drop", 32'(cpu_en), 32'd0);
    load_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_load(1'b1);
    chk("w6_word_count", 32'(word_count), 32'd2);
    model_commit();
    fetch_check(32'h0000_0000);
    chk("w6_word0", insn, 32'h4433_2211);
    fetch_check(32'h0000_0004);
    chk("w6_word1", insn, 32'h0000_6655);

    // boot_start together with a valid byte: byte dropped, load restarts
    pulse_boot();
    load_q = '{8'hEE};
    send_load(1'b0);
    boot_start = 1'b1; load_valid = 1'b1; load_byte = 8'h77;
    step();
    boot_start = 1'b0; load_valid = 1'b0;
    chk("restart_word_count", 32'(word_count), 32'd0);
    load_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_load(1'b1);
    chk("restart_word_count_after", 32'(word_count), 32'd1);
    model_commit();
    fetch_check(32'h0000_0000);

    // Randomized images and fetches
    repeat (6) begin
      int n;
      n = $urandom_range(1, 40);
      load_q = {};
      for (int i = 0; i < n; i++) load_q.push_back(8'($urandom));
      pulse_boot();
      send_load(1'b1);
      nw = (n + 3) / 4;
      chk("rnd_word_count", 32'(word_count), 32'(nw));
      chk("rnd_load_done", 32'(load_done), 32'd1);
      chk("rnd_load_err", 32'(load_err), 32'd0);
      model_commit();
      repeat (5) begin
        logic [31:0] a;
        int sel;
        sel = $urandom_range(0, 3);
        a   = {18'h0, 12'($urandom_range(0, nw - 1)), 2'b00};
        if (sel == 2) a[1:0] = 2'($urandom_range(1, 3));
        if (sel == 3) begin
          a = $urandom;
          if (a[31:14] == 18'h0) a[20] = 1'b1;
        end
        fetch_check(a);
      end
    end

    // Overflow: full RAM without load_last
    pulse_boot();
    load_q = {};
    acc = 0;
    for (int i = 0; i <= 4 * DEPTH; i++) begin
      load_valid = 1'b1;
      load_byte  = 8'(i ^ (i >> 8));
      if (load_ready) begin
        acc++;
        load_q.push_back(load_byte);
      end
      step();
    end
    load_valid = 1'b0;
    chk("ovf_accepted", 32'(acc), 32'(4 * DEPTH));
    chk("ovf_load_err", 32'(load_err), 32'd1);
    chk("ovf_load_done", 32'(load_done), 32'd1);
    chk("ovf_load_ready", 32'(load_ready), 32'd0);
    chk("ovf_word_count", 32'(word_count), 32'(DEPTH));
    chk("ovf_cpu_en", 32'(cpu_en), 32'd1);
    model_commit();
    fetch_check(32'h0000_3FFC);
    fetch_check(32'h0000_0000);
    fetch_check({18'h0, 12'($urandom), 2'b00});
    fetch_check(32'h0000_0004);

    // boot_start in RUN clears status and drops cpu_en next cycle
    pulse_boot();
    chk("rerun_cpu_en", 32'(cpu_en), 32'd0);
    chk("rerun_load_done", 32'(load_done), 32'd0);
    chk("rerun_load_err", 32'(load_err), 32'd0);
    chk("rerun_word_count", 32'(word_count), 32'd0);
    chk("rerun_insn", insn, NOP);

    // Reset mid-load after two bytes, then a fresh load from word 0 / byte 0
    load_q = '{8'h01, 8'h02};
    send_load(1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_cpu_en", 32'(cpu_en), 32'd0);
    chk("midrst_load_ready", 32'(load_ready), 32'd0);
    chk("midrst_word_count", 32'(word_count), 32'd0);
    chk("midrst_insn", insn, NOP);
    pulse_boot();
    load_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_load(1'b1);
    chk("midrst_reload_count", 32'(word_count), 32'd1);
    model_commit();
    fetch_check(32'h0000_0000);
    chk("midrst_word0", insn, 32'hDDCC_BBAA);
    fetch_check(32'h0000_0004);
    fetch_check(32'h0000_3FFC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
